// File: rtl/person_event_gen_pkg.sv
// Shared definitions for the person event generator and the occupancy counter
// that consumes its Selector/Increment commands.
package person_event_gen_pkg;

  // Command codes carried on Selector.
  localparam logic [7:0] SEL_IDLE   = 8'd0;
  localparam logic [7:0] SEL_ADD    = 8'd4;
  localparam logic [7:0] SEL_REMOVE = 8'd20;

  // Command sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAITREL
  } state_t;

endpackage

// File: rtl/person_event_gen_btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stability counter.
// The debounced level follows the synchronized button only after it has held
// the opposite value for DEBOUNCE_CYCLES consecutive cycles; press pulses for
// one cycle, in the same cycle the debounced level first reads 1.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  // Count consecutive cycles of disagreement; flip the level when the run completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/person_event_gen.sv
// person_event_gen: turns debounced Enter/Exit button presses into registered
// Selector/Increment command sequences (SETUP, STROBE, HOLD) for the occupancy
// counter.
// Optional feature: define PERSON_EVENT_AUTO_REPEAT_EN to repeat the command
// every REPEAT_CYCLES cycles (counted from HOLD exit) while exactly the same
// single button stays pressed. Without it no repeat counter exists.
module person_event_gen
  import person_event_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       EnterBtn,
  input  logic       ExitBtn,
  output logic [7:0] Selector,
  output logic       Increment,
  output logic       Busy
);

  // Reject parameter values the strobe counter and repeat timer cannot honour.
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 255 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("person_event_gen: STROBE_CYCLES must be 1..255 and REPEAT_CYCLES >= 1");
  end

  localparam logic [7:0] STRB_LAST = 8'(STROBE_CYCLES - 1);

  logic       enter_lvl, enter_press;
  logic       exit_lvl,  exit_press;
  state_t     state, state_d;
  logic [7:0] sel_d;
  logic       inc_d;
  logic [7:0] strb_cnt, strb_cnt_d;

`ifdef PERSON_EVENT_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [7:0]       cmd_q, cmd_d;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;
  logic             same_btn_held;

  // Only the button that issued the last command, held alone, keeps repeating.
  assign same_btn_held = (cmd_q == SEL_ADD) ? (enter_lvl && !exit_lvl)
                                            : (exit_lvl && !enter_lvl);
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (Clock),
    .rst_n (Reset_n),
    .btn   (EnterBtn),
    .level (enter_lvl),
    .press (enter_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk   (Clock),
    .rst_n (Reset_n),
    .btn   (ExitBtn),
    .level (exit_lvl),
    .press (exit_press)
  );

  assign Busy = (state != IDLE);

  // Next state plus the next values of the registered command outputs.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    sel_d      = Selector;
    inc_d      = 1'b0;
    strb_cnt_d = strb_cnt;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
    cmd_d      = cmd_q;
    rpt_cnt_d  = rpt_cnt;
`endif
    unique case (state)
      IDLE: begin
        sel_d = SEL_IDLE;
        // Simultaneous presses are ambiguous: issue nothing, wait for release.
        if (enter_press && exit_press) begin
          state_d = WAITREL;
        end else if (enter_press) begin
          state_d = SETUP;
          sel_d   = SEL_ADD;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
          cmd_d   = SEL_ADD;
`endif
        end else if (exit_press) begin
          state_d = SETUP;
          sel_d   = SEL_REMOVE;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
          cmd_d   = SEL_REMOVE;
`endif
        end
      end
      SETUP: begin
        // Selector has now been stable for a full cycle; raise Increment next.
        state_d    = STROBE;
        inc_d      = 1'b1;
        strb_cnt_d = '0;
      end
      STROBE: begin
        if (strb_cnt == STRB_LAST) begin
          state_d = HOLD;
        end else begin
          inc_d      = 1'b1;
          strb_cnt_d = strb_cnt + 8'd1;
        end
      end
      HOLD: begin
        state_d = WAITREL;
        sel_d   = SEL_IDLE;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
        rpt_cnt_d = '0;
`endif
      end
      WAITREL: begin
        sel_d = SEL_IDLE;
        if (!enter_lvl && !exit_lvl) begin
          state_d = IDLE;
        end
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
        else if (same_btn_held) begin
          if (rpt_cnt == RPT_LAST) begin
            state_d   = SETUP;
            sel_d     = cmd_q;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt + RPT_W'(1);
          end
        end else begin
          rpt_cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
      end
    endcase
  end

  // State and glitch-free registered outputs; reset clears them immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      Selector  <= SEL_IDLE;
      Increment <= 1'b0;
      strb_cnt  <= '0;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
      cmd_q     <= SEL_IDLE;
      rpt_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      Selector  <= sel_d;
      Increment <= inc_d;
      strb_cnt  <= strb_cnt_d;
`ifdef PERSON_EVENT_AUTO_REPEAT_EN
      cmd_q     <= cmd_d;
      rpt_cnt   <= rpt_cnt_d;
`endif
    end
  end

endmodule
